// File: rtl/ccg_sig_sweep_if.sv
// Stimulus/response bundle between the sweep harness and its circuit under test.
// The slave side is the harness; the master side is whoever drives the sweep
// controls and supplies the CUT response.
interface ccg_sig_sweep_if #(
  parameter int N_IN  = 11,
  parameter int N_OUT = 30,
  parameter int SIG_W = 32
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [31:0]      vec_limit;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [31:0]      vec_count;

  modport master (
    output start, abort, mode, vec_limit, dut_out,
    input  dut_in, busy, done, signature, vec_count
  );

  modport slave (
    input  start, abort, mode, vec_limit, dut_out,
    output dut_in, busy, done, signature, vec_count
  );
endinterface

// File: rtl/ccg_sig_sweep.sv
// Signature sweep harness: drives an exhaustive or LFSR vector sequence onto a
// combinational (optionally pipelined) CUT and compacts every response into a
// MISR so two netlists of the same function can be compared by signature.
module ccg_sig_sweep #(
  parameter int          N_IN  = 11,
  parameter int          N_OUT = 30,
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF,
  parameter int          LAT   = 0
) (
  input logic            clk,
  input logic            rst,
  ccg_sig_sweep_if.slave bus
);

  localparam logic [31:0]     LFSR_TAPS = 32'h80200003;
  localparam logic [N_IN-1:0] VIN_ONE   = N_IN'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic              mode_r;
  logic [31:0]       rem_r;      // vectors still to issue, including the current one
  logic [31:0]       drain_r;
  logic [31:0]       lfsr_r;
  logic [N_IN-1:0]   dut_in_r;
  logic [SIG_W-1:0]  sig_r;
  logic [31:0]       cnt_r;
  logic              busy_r;
  logic              done_r;

  logic              start_ok_s;
  logic [31:0]       v_s;
  logic              issue_s;
  logic [31:0]       lfsr_nx_s;
  logic              cap_s;

  // One right-shift step of the 32-bit Galois stimulus LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // MISR update with the CUT word folded down to SIG_W bits: bit i lands in
  // position i mod SIG_W, which XORs consecutive chunks and zero-extends the tail.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [N_OUT-1:0] d);
    logic [SIG_W-1:0] f;
    f = {SIG_W{1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      f[i % SIG_W] = f[i % SIG_W] ^ d[i];
    end
    misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY[SIG_W-1:0] : {SIG_W{1'b0}}) ^ f;
  endfunction

  // Sweep-level qualifiers shared by the sequencer and the datapath.
  always_comb begin
    start_ok_s = 1'b0;
    v_s        = 32'd0;
    issue_s    = 1'b0;
    lfsr_nx_s  = lfsr_step(lfsr_r);
    if (state_r == ST_IDLE) begin
      start_ok_s = bus.start && !bus.abort;
    end else begin
      start_ok_s = 1'b0;
    end
    if (bus.mode) begin
      v_s = bus.vec_limit;
    end else begin
      v_s = 32'd1 << N_IN;
    end
    if ((state_r == ST_RUN) && (rem_r != 32'd0)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state decode for the sweep sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_n = ST_RUN;
        else            state_n = ST_IDLE;
      end
      ST_RUN: begin
        // rem_r == 0 only for an empty LFSR sweep, which skips the drain.
        if (bus.abort)                              state_n = ST_IDLE;
        else if (rem_r > 32'd1)                     state_n = ST_RUN;
        else if ((LAT > 0) && (rem_r == 32'd1))     state_n = ST_DRAIN;
        else                                        state_n = ST_DONE;
      end
      ST_DRAIN: begin
        if (bus.abort)               state_n = ST_IDLE;
        else if (drain_r == 32'd0)   state_n = ST_DONE;
        else                         state_n = ST_DRAIN;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n;
  end

  // Capture qualifier: a response is valid LAT cycles after its vector issued.
  generate
    if (LAT == 0) begin : g_comb_cut
      assign cap_s = issue_s;
    end else begin : g_piped_cut
      logic [LAT-1:0] vld_r;

      // Valid pipeline tracking in-flight vectors; an abort discards them.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_r <= {LAT{1'b0}};
        end else if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && bus.abort) begin
          vld_r <= {LAT{1'b0}};
        end else begin
          vld_r <= LAT'({vld_r, issue_s});
        end
      end

      assign cap_s = vld_r[LAT-1];
    end
  endgenerate

  // Sweep datapath: latch a new sweep, advance the stimulus, compact responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= 1'b0;
      rem_r    <= 32'd0;
      drain_r  <= 32'd0;
      lfsr_r   <= SEED;
      dut_in_r <= {N_IN{1'b0}};
      sig_r    <= SEED[SIG_W-1:0];
      cnt_r    <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done_r <= (state_n == ST_DONE);
      if (start_ok_s) begin
        mode_r  <= bus.mode;
        rem_r   <= v_s;
        lfsr_r  <= SEED;
        sig_r   <= SEED[SIG_W-1:0];
        cnt_r   <= 32'd0;
        if (v_s != 32'd0) begin
          dut_in_r <= bus.mode ? SEED[N_IN-1:0] : {N_IN{1'b0}};
        end
      end else begin
        if (issue_s) begin
          rem_r <= rem_r - 32'd1;
          // The last vector (and an aborted one) stays on the CUT inputs.
          if (!bus.abort && (rem_r != 32'd1)) begin
            lfsr_r   <= lfsr_nx_s;
            dut_in_r <= mode_r ? lfsr_nx_s[N_IN-1:0] : dut_in_r + VIN_ONE;
          end
        end
        if ((state_r == ST_RUN) && (state_n == ST_DRAIN)) begin
          drain_r <= 32'(LAT - 1);
        end else if ((state_r == ST_DRAIN) && (drain_r != 32'd0)) begin
          drain_r <= drain_r - 32'd1;
        end
        if (cap_s) begin
          sig_r <= misr_step(sig_r, bus.dut_out);
          if (cnt_r != 32'hFFFF_FFFF) begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
      end
    end
  end

  assign bus.dut_in    = dut_in_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.signature = sig_r;
  assign bus.vec_count = cnt_r;

endmodule

// File: tb/tb_ccg_sig_sweep.sv
// Bench for ccg_sig_sweep: two small instances (LAT 0 and LAT 2) share cycle
// tables for the hand-traced scenarios; a wider instance (LAT 1, folded
// outputs, non-zero seed) runs random sweeps against a reference model.
module tb_ccg_sig_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode;
  logic [31:0] vec_limit;
  logic        cut_sel;
  logic [31:0] key;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ccg_sig_sweep_if #(.N_IN(2), .N_OUT(1),  .SIG_W(4)) if0 ();
  ccg_sig_sweep_if #(.N_IN(2), .N_OUT(1),  .SIG_W(4)) if1 ();
  ccg_sig_sweep_if #(.N_IN(5), .N_OUT(11), .SIG_W(8)) if2 ();

  assign if0.start = start;  assign if0.abort = abort;
  assign if0.mode  = mode;   assign if0.vec_limit = vec_limit;
  assign if1.start = start;  assign if1.abort = abort;
  assign if1.mode  = mode;   assign if1.vec_limit = vec_limit;
  assign if2.start = start;  assign if2.abort = abort;
  assign if2.mode  = mode;   assign if2.vec_limit = vec_limit;

  function automatic logic plan_cut(input logic [1:0] v, input logic sel);
    return sel ? v[0] : (v[0] & v[1]);
  endfunction

  function automatic logic [10:0] cutf(input logic [4:0] v, input logic [31:0] k);
    logic [31:0] p;
    p = ({27'd0, v} * {16'd0, k[15:0]}) ^ {21'd0, k[26:16]};
    return p[10:0];
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // CUT models: combinational, two-register delayed, one-register delayed.
  logic        d1_r, d2_r;
  logic [10:0] r2_r;
  assign if0.dut_out = plan_cut(if0.dut_in, cut_sel);
  always @(posedge clk) begin
    d1_r <= plan_cut(if1.dut_in, cut_sel);
    d2_r <= d1_r;
    r2_r <= cutf(if2.dut_in, key);
  end
  assign if1.dut_out = d2_r;
  assign if2.dut_out = r2_r;

  ccg_sig_sweep #(.N_IN(2), .N_OUT(1), .SIG_W(4), .POLY(32'h3), .SEED(32'h0), .LAT(0))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  ccg_sig_sweep #(.N_IN(2), .N_OUT(1), .SIG_W(4), .POLY(32'h3), .SEED(32'h0), .LAT(2))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  ccg_sig_sweep #(.N_IN(5), .N_OUT(11), .SIG_W(8), .POLY(32'h1D), .SEED(32'hACE12345), .LAT(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic       rst_i, start_i, abort_i;
    logic [1:0] din0;  logic busy0, done0; logic [2:0] cnt0; logic [3:0] sig0;
    logic [1:0] din1;  logic busy1, done1; logic [2:0] cnt1;
  } row_t;

  row_t tab[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int r, input int st, input int ab,
                     input int d0, input int b0, input int o0, input int c0, input int s0,
                     input int d1, input int b1, input int o1, input int c1);
    row_t x;
    x.rst_i = r[0];  x.start_i = st[0]; x.abort_i = ab[0];
    x.din0 = d0[1:0]; x.busy0 = b0[0]; x.done0 = o0[0]; x.cnt0 = c0[2:0]; x.sig0 = s0[3:0];
    x.din1 = d1[1:0]; x.busy1 = b1[0]; x.done1 = o1[0]; x.cnt1 = c1[2:0];
    tab.push_back(x);
  endtask

  // Each row: inputs held during one cycle, outputs expected in that cycle.
  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      rst = tab[i].rst_i; start = tab[i].start_i; abort = tab[i].abort_i;
      check($sformatf("%s%0d_din0", tag, i), 64'(if0.dut_in),    64'(tab[i].din0));
      check($sformatf("%s%0d_busy0", tag, i), 64'(if0.busy),     64'(tab[i].busy0));
      check($sformatf("%s%0d_done0", tag, i), 64'(if0.done),     64'(tab[i].done0));
      check($sformatf("%s%0d_cnt0", tag, i), 64'(if0.vec_count), 64'(tab[i].cnt0));
      check($sformatf("%s%0d_sig0", tag, i), 64'(if0.signature), 64'(tab[i].sig0));
      check($sformatf("%s%0d_din1", tag, i), 64'(if1.dut_in),    64'(tab[i].din1));
      check($sformatf("%s%0d_busy1", tag, i), 64'(if1.busy),     64'(tab[i].busy1));
      check($sformatf("%s%0d_done1", tag, i), 64'(if1.done),     64'(tab[i].done1));
      check($sformatf("%s%0d_cnt1", tag, i), 64'(if1.vec_count), 64'(tab[i].cnt1));
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tab.delete();
  endtask

  int          vtot;
  int          n;
  bit          got_done;
  logic [4:0]  ev[$];
  logic [7:0]  esig;
  logic [31:0] l;
  logic [10:0] r;
  logic [7:0]  f;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; vec_limit = 32'd0;
    cut_sel = 1'b0; key = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_din0", 64'(if0.dut_in), 64'd0);
    check("rst_busy0", 64'(if0.busy), 64'd0);
    check("rst_done0", 64'(if0.done), 64'd0);
    check("rst_cnt0", 64'(if0.vec_count), 64'd0);
    check("rst_sig2", 64'(if2.signature), 64'h45);
    check("rst_din2", 64'(if2.dut_in), 64'd0);

    // Exhaustive sweep, CUT = AND; a start during RUN and in DONE is ignored.
    //   r st ab  din0 b0 o0 c0 s0  din1 b1 o1 c1
    add(0, 1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0, 0,   0, 1, 0, 0);
    add(0, 1, 0,  1, 1, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0,  2, 1, 0, 2, 0,   2, 1, 0, 0);
    add(0, 0, 0,  3, 1, 0, 3, 0,   3, 1, 0, 1);
    add(0, 1, 0,  3, 0, 1, 4, 1,   3, 1, 0, 2);
    add(0, 0, 0,  3, 0, 0, 4, 1,   3, 1, 0, 3);
    add(0, 0, 0,  3, 0, 0, 4, 1,   3, 0, 1, 4);
    add(0, 0, 0,  3, 0, 0, 4, 1,   3, 0, 0, 4);
    run_tab("and");
    check("and_sig1", 64'(if1.signature), 64'h1);

    // Same sweep with CUT = dut_in[0].
    cut_sel = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    check("bit0_sig0", 64'(if0.signature), 64'h5);
    check("bit0_cnt0", 64'(if0.vec_count), 64'd4);
    check("bit0_sig1", 64'(if1.signature), 64'h5);
    check("bit0_cnt1", 64'(if1.vec_count), 64'd4);

    // Abort at T2, abort+start in IDLE, restart, then reset mid-sweep.
    add(0, 1, 0,  3, 0, 0, 4, 5,   3, 0, 0, 4);
    add(0, 0, 0,  0, 1, 0, 0, 0,   0, 1, 0, 0);
    add(0, 0, 1,  1, 1, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 2, 1,   1, 0, 0, 0);
    add(0, 1, 1,  1, 0, 0, 2, 1,   1, 0, 0, 0);
    add(0, 1, 0,  1, 0, 0, 2, 1,   1, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0, 0,   0, 1, 0, 0);
    add(0, 0, 0,  1, 1, 0, 1, 0,   1, 1, 0, 0);
    add(1, 0, 0,  2, 1, 0, 2, 1,   2, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    run_tab("abt");
    check("abt_sig2", 64'(if2.signature), 64'h45);
    check("abt_busy2", 64'(if2.busy), 64'd0);

    // LFSR mode with an empty vector budget: straight to DONE.
    mode = 1'b1; vec_limit = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    check("v0_done_t1", 64'(if0.done), 64'd0);
    tick();
    check("v0_done_t2", 64'(if0.done), 64'd1);
    check("v0_busy_t2", 64'(if0.busy), 64'd0);
    check("v0_cnt", 64'(if0.vec_count), 64'd0);
    check("v0_sig", 64'(if0.signature), 64'd0);
    tick();

    // LFSR mode, five vectors; a zero seed keeps the LFSR at zero.
    vec_limit = 32'd5;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("v5_din_t%0d", k), 64'(if0.dut_in), 64'd0);
      check($sformatf("v5_busy_t%0d", k), 64'(if0.busy), 64'd1);
      tick();
    end
    check("v5_done", 64'(if0.done), 64'd1);
    check("v5_cnt", 64'(if0.vec_count), 64'd5);
    repeat (4) tick();

    // Random sweeps on the wide instance against the reference model.
    for (int s = 0; s < 10; s++) begin
      mode      = 1'($urandom_range(0, 1));
      vec_limit = 32'($urandom_range(0, 40));
      key       = $urandom;
      vtot      = mode ? int'(vec_limit) : 32;
      ev.delete();
      l    = 32'hACE12345;
      esig = 8'h45;
      for (int i = 0; i < vtot; i++) begin
        if (mode) begin
          ev.push_back(l[4:0]);
          l = lfsr_adv(l);
        end else begin
          ev.push_back(5'(i));
        end
        r    = cutf(ev[i], key);
        f    = r[7:0] ^ {5'd0, r[10:8]};
        esig = {esig[6:0], 1'b0} ^ (esig[7] ? 8'h1D : 8'h00) ^ f;
      end
      start = 1'b1; tick(); start = 1'b0;
      mode = ~mode; vec_limit = $urandom;
      n = 1;
      got_done = 1'b0;
      while ((n < 100) && !got_done) begin
        if (if2.done) begin
          got_done = 1'b1;
        end else begin
          if (n <= vtot) check($sformatf("rnd%0d_din_t%0d", s, n), 64'(if2.dut_in), 64'(ev[n-1]));
          n++;
          tick();
        end
      end
      check($sformatf("rnd%0d_done_at", s), got_done ? 64'(n) : 64'd0,
            (vtot == 0) ? 64'd2 : 64'(vtot + 2));
      check($sformatf("rnd%0d_sig", s), 64'(if2.signature), 64'(esig));
      check($sformatf("rnd%0d_cnt", s), 64'(if2.vec_count), 64'(vtot));
      check($sformatf("rnd%0d_busy", s), 64'(if2.busy), 64'd0);
      tick();
      check($sformatf("rnd%0d_done_pulse", s), 64'(if2.done), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
